liteeth_sram_fifo_ctrl: RTL
===========================

# liteeth_sram_fifo_ctrl

Synchronous stream FIFO controller that turns the dual-port `fakeram_1rw1r_32w384d_sram` macro into a 384-deep, 32-bit valid/ready FIFO for the LiteEth MAC TX/RX buffering path. It drives the macro's `rw0` port as the write side and its `r0` port as the read side. A 2-entry output stage absorbs the macro's 1-cycle read latency so the FIFO sustains one word per cycle in and out. The macro's `r0_clk` and `rw0_clk` are tied to `sys_clk` at the integration level.

## Interface
Parameters:
- `BITS`, 32, word width; must equal the macro's `BITS`.
- `DEPTH`, 384, SRAM words; need not be a power of two.
- `ADDR_WIDTH`, 9, SRAM address width; `2**ADDR_WIDTH >= DEPTH`.
- `LEVEL_WIDTH`, 10, width of `level`; must hold `DEPTH+2`.
- `AF_MARGIN`, 8, almost-full margin (watermark build only).
- `AE_MARGIN`, 8, almost-empty margin (watermark build only).

Ports:
- `sys_clk  in  1`  clock; one clock for all logic. Reset is synchronous and active-high.
- `sys_rst  in  1`  synchronous active-high reset.
- `sink_valid  in  1`, `sink_ready  out  1`, `sink_data  in  BITS`  write stream.
- `source_valid  out  1`, `source_ready  in  1`, `source_data  out  BITS`  read stream.
- `level  out  LEVEL_WIDTH`  words held: SRAM + in-flight + output stage.
- `rw0_ce_in  out  1`, `rw0_we_in  out  1`, `rw0_addr_in  out  ADDR_WIDTH`, `rw0_wd_in  out  BITS`  to the macro's write port.
- `r0_ce_in  out  1`, `r0_addr_in  out  ADDR_WIDTH`  to the macro's read port.
- `r0_rd_out  in  BITS`  read data from the macro.
- `almost_full  out  1`, `almost_empty  out  1`  present only with `LITEETH_SRAM_FIFO_WATERMARK_EN`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`: 0..DEPTH-1; each wraps from DEPTH-1 to 0.
  - `mem_count`: 0..DEPTH.
  - `inflight`: 0/1.
  - `stage_count`: 0..2, FIFO-ordered output stage.
- Write:
  - `sink_ready = !sys_rst && mem_count != DEPTH`.
  - `push = sink_valid && sink_ready`.
  - `rw0_ce_in = rw0_we_in = push`, `rw0_addr_in = wr_ptr`, `rw0_wd_in = sink_data`.
  - On push, `wr_ptr` advances.
- Read issue:
  - `pop = source_valid && source_ready`.
  - `issue = !sys_rst && mem_count != 0 && (stage_count + inflight - pop) < 2`.
  - `r0_ce_in = issue`, `r0_addr_in = rd_ptr`.
  - On issue, `rd_ptr` advances and `inflight` is set for the next cycle.
- Capture: when `inflight` is 1, `r0_rd_out` is written into the output stage behind any held entry. `r0_rd_out` is never sampled in any other cycle; its X-when-idle value is ignored.
- `mem_count` next value = `mem_count + push - issue`. Simultaneous push and issue leave it unchanged.
- Read-after-write: issue depends only on the registered `mem_count`, so a word is never read in the same cycle it is written.
- Outputs:
  - `source_valid = stage_count != 0`.
  - `source_data` = head of the output stage, held stable while `source_valid && !source_ready`.
  - `level = mem_count + inflight + stage_count`; maximum value is DEPTH+2.
- Reset:
  - Clears pointers, counts, `inflight`, and the stage.
  - A read in flight when reset asserts is discarded.
  - No SRAM contents are cleared.

## Timing
- Reset values:
  - `sink_ready`=0 while `sys_rst`=1; 1 in the first cycle after release.
  - `source_valid`=0, `level`=0, `rw0_ce_in`=0, `rw0_we_in`=0, `r0_ce_in`=0.
  - `rw0_addr_in`=0, `r0_addr_in`=0, `source_data`=0.
- Latency: a push accepted at edge N gives `source_valid`=1 after edge N+2, with an empty FIFO and `source_ready`=1. Sequence: issue at N+1, capture at N+2.
- Throughput: 1 word/cycle sustained in both directions with `source_ready` held high.
- Full:
  - `sink_ready` drops in the cycle after the DEPTH-th word sits in the SRAM.
  - A same-cycle issue frees space visible the next cycle.
- Empty: `source_valid` drops right after the last stage entry pops, when no read is in flight.
- All SRAM control outputs are combinational from registered state plus `sink_valid`/`sink_data`/`source_ready`. The macro registers them.

## Configuration
- `LITEETH_SRAM_FIFO_WATERMARK_EN` defined:
  - `almost_full = level >= DEPTH+2-AF_MARGIN` and `almost_empty = level <= AE_MARGIN`, both registered and updated one cycle after `level`.
  - Reset values: `almost_full`=0, `almost_empty`=1.
- Macro undefined: both ports and their logic are absent. Everything else is identical.

## Test plan
- Reset, then a single push of 0xDEADBEEF at edge N → `source_valid` rises after N+2 with `source_data`=0xDEADBEEF; `level` reads 1, 1, 1, then 0 after the pop.
- Stream 1000 incrementing words with `source_ready`=1 → output order matches input, no bubbles after the first word, `level` never exceeds 3.
- Hold `source_ready`=0 and push until `sink_ready`=0 → exactly 386 pushes are accepted (384 in SRAM + 2 in the stage), and `level`=386.
- Wrap-around: push and pop 800 words with random `source_ready` → `rw0_addr_in` and `r0_addr_in` go 383 → 0, and data stays intact.
- Assert `sys_rst` for 1 cycle with `inflight`=1 and 5 words held → next cycle `level`=0, `source_valid`=0. The next push of 0x1 emerges first.
- Watermark build, AF_MARGIN=8: fill to `level`=378 → `almost_full` rises one cycle later. Drain to 8 → `almost_empty`=1.

Source files
------------

// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl: 384x32 SRAM-backed valid/ready FIFO (rw0 = write, r0 = read) with a 2-entry output stage hiding the 1-cycle read latency; optional LITEETH_SRAM_FIFO_WATERMARK_EN adds registered almost_full/almost_empty
module liteeth_sram_fifo_ctrl #(
  parameter int BITS        = 32,
  parameter int DEPTH       = 384,
  parameter int ADDR_WIDTH  = 9,
  parameter int LEVEL_WIDTH = 10,
  parameter int AF_MARGIN   = 8,
  parameter int AE_MARGIN   = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic [BITS-1:0]        sink_data,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic [BITS-1:0]        source_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   rw0_ce_in,
  output logic                   rw0_we_in,
  output logic [ADDR_WIDTH-1:0]  rw0_addr_in,
  output logic [BITS-1:0]        rw0_wd_in,
  output logic                   r0_ce_in,
  output logic [ADDR_WIDTH-1:0]  r0_addr_in,
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  output logic                   almost_full,
  output logic                   almost_empty,
`endif
  input  logic [BITS-1:0]        r0_rd_out
);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] mem_count_q, mem_count_d;
  logic inflight_q, push, pop, issue;
  logic [1:0] stage_count_q, stage_count_d, keep;
  logic [BITS-1:0] stage0_q, stage0_d, stage1_q, stage1_d;
  always_comb begin
    sink_ready = !sys_rst && mem_count_q != LEVEL_WIDTH'(DEPTH);
    push = sink_valid && sink_ready;
    source_valid = stage_count_q != 2'd0;
    source_data = stage0_q;
    pop = source_valid && source_ready;
    keep = stage_count_q - {1'b0, pop};
    stage_count_d = keep + {1'b0, inflight_q};
    // stage_count_d is the occupancy once this cycle's pop and capture land,
    // so a new read is only launched when it is guaranteed a free slot.
    issue = !sys_rst && mem_count_q != '0 && !stage_count_d[1];
    stage0_d = (inflight_q && keep == 2'd0) ? r0_rd_out : pop ? stage1_q : stage0_q;
    stage1_d = (inflight_q && keep != 2'd0) ? r0_rd_out : stage1_q;
    mem_count_d = mem_count_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(issue);
    wr_ptr_d = !push ? wr_ptr_q : wr_ptr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    rd_ptr_d = !issue ? rd_ptr_q : rd_ptr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    rw0_ce_in = push;
    rw0_we_in = push;
    rw0_addr_in = wr_ptr_q;
    rw0_wd_in = sink_data;
    r0_ce_in = issue;
    r0_addr_in = rd_ptr_q;
    level = mem_count_q + LEVEL_WIDTH'(inflight_q) + LEVEL_WIDTH'(stage_count_q);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_count_q <= '0;
      inflight_q <= 1'b0;
      stage_count_q <= 2'd0;
      stage0_q <= '0;
      stage1_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q <= issue;
      stage_count_q <= stage_count_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
    end
  end
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full <= level >= LEVEL_WIDTH'(DEPTH + 2 - AF_MARGIN);
      almost_empty <= level <= LEVEL_WIDTH'(AE_MARGIN);
    end
  end
`endif
endmodule
